// File: rtl/anemo_pkg.sv
// anemo_pkg -- shared definitions for the anemometer log master.
//   DEPTH_DEFAULT  : default number of 32-bit words in the log RAM
//   ADDR_W_DEFAULT : default word-address width
//   state_t        : controller state encoding
package anemo_pkg;

  localparam int unsigned DEPTH_DEFAULT  = 12000;
  localparam int unsigned ADDR_W_DEFAULT = 14;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    READ_ISSUE = 2'd2,
    READ_WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/anemo_log_master_if.sv
// anemo_log_master_if -- Avalon-MM bus between the log master and the log RAM.
//   address     : word address
//   byteenable  : byte lanes (all four for a full word)
//   chipselect  : transfer request
//   write       : 1 = write transfer, 0 = read transfer
//   writedata   : write payload
//   readdata    : read payload, valid a fixed latency after read acceptance
//   waitrequest : slave stall; the master holds its request while high
interface anemo_log_master_if #(
  parameter int unsigned ADDR_W = anemo_pkg::ADDR_W_DEFAULT
);

  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              chipselect;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              waitrequest;

  modport master (
    output address, byteenable, chipselect, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata,
    output readdata, waitrequest
  );

endinterface

// File: rtl/anemo_log_master.sv
// anemo_log_master -- logs wind-speed samples into a circular word RAM over
// Avalon-MM and serves single-word read-back requests.
//   clk, reset_n      : clock, asynchronous active-low reset
//   clear             : resets write pointer and wrap flag (acted on in IDLE)
//   sample_*          : valid/ready sample input
//   rd_req, rd_index  : read-back request pulse and word index
//   rd_data, rd_valid,
//   rd_err            : read-back result, qualified by the one-cycle rd_valid
//   wr_ptr, wrapped   : next write index, sticky wrap-around flag
//   avm               : Avalon-MM master port (registered outputs)
module anemo_log_master
  import anemo_pkg::*;
#(
  parameter int unsigned DEPTH        = DEPTH_DEFAULT,
  parameter int unsigned ADDR_W       = ADDR_W_DEFAULT,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [31:0]           sample_data,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic                  rd_req,
  input  logic [ADDR_W-1:0]     rd_index,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic                  rd_err,
  output logic [ADDR_W-1:0]     wr_ptr,
  output logic                  wrapped,
  anemo_log_master_if.master    avm
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        LAT      = 2'(READ_LATENCY);

  state_t            state_reg;
  logic              pend_reg;
  logic [ADDR_W-1:0] pend_idx_reg;
  logic [1:0]        lat_cnt_reg;
  logic              pend_oob;
  logic              read_take;

  assign sample_ready = (state_reg == IDLE) && !clear;
  assign pend_oob     = (32'(pend_idx_reg) >= DEPTH);
  // The pending read is consumed only in an IDLE cycle that neither clears
  // nor accepts a sample (samples win over reads).
  assign read_take    = (state_reg == IDLE) && !clear && !sample_valid && pend_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      pend_reg       <= 1'b0;
      pend_idx_reg   <= '0;
      lat_cnt_reg    <= '0;
      wr_ptr         <= '0;
      wrapped        <= 1'b0;
      rd_data        <= '0;
      rd_valid       <= 1'b0;
      rd_err         <= 1'b0;
      avm.address    <= '0;
      avm.byteenable <= '0;
      avm.chipselect <= 1'b0;
      avm.write      <= 1'b0;
      avm.writedata  <= '0;
    end else begin
      rd_valid <= 1'b0;

      // A new request always wins, even in the cycle the old one is consumed,
      // so a request arriving then is served afterwards rather than lost.
      if (rd_req) begin
        pend_reg     <= 1'b1;
        pend_idx_reg <= rd_index;
      end else if (read_take) begin
        pend_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (clear) begin
            wr_ptr  <= '0;
            wrapped <= 1'b0;
          end else if (sample_valid) begin
            avm.address    <= wr_ptr;
            avm.writedata  <= sample_data;
            avm.byteenable <= 4'hF;
            avm.chipselect <= 1'b1;
            avm.write      <= 1'b1;
            state_reg      <= WRITE;
          end else if (pend_reg) begin
            if (pend_oob) begin
              // Out-of-range index is answered locally, no bus cycle.
              rd_data  <= '0;
              rd_err   <= 1'b1;
              rd_valid <= 1'b1;
            end else begin
              avm.address    <= pend_idx_reg;
              avm.byteenable <= 4'hF;
              avm.chipselect <= 1'b1;
              avm.write      <= 1'b0;
              state_reg      <= READ_ISSUE;
            end
          end
        end

        WRITE: begin
          if (!avm.waitrequest) begin
            avm.chipselect <= 1'b0;
            avm.write      <= 1'b0;
            avm.byteenable <= '0;
            if (wr_ptr == LAST_IDX) begin
              wr_ptr  <= '0;
              wrapped <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
            state_reg <= IDLE;
          end
        end

        READ_ISSUE: begin
          if (!avm.waitrequest) begin
            avm.chipselect <= 1'b0;
            avm.byteenable <= '0;
            // The first READ_WAIT cycle is already one cycle after acceptance.
            lat_cnt_reg    <= 2'd1;
            state_reg      <= READ_WAIT;
          end
        end

        READ_WAIT: begin
          if (lat_cnt_reg >= LAT) begin
            rd_data   <= avm.readdata;
            rd_err    <= 1'b0;
            rd_valid  <= 1'b1;
            state_reg <= IDLE;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 2'd1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
